// File: rtl/mult_div_pkg.sv
// ---------------------------------------------------------------------------
// mult_div_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - operation encodings as seen on the 'op' input
//   - FSM state encodings
//   - default data width, iteration count and iteration-counter width
// ---------------------------------------------------------------------------
package mult_div_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int N_ITER     = 32;
   localparam int CNT_WIDTH  = 5;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } opT;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIM  = 2'b10
   } stateT;

endpackage

// File: rtl/passo_mult_div.sv
// ---------------------------------------------------------------------------
// passo_mult_div
// Purely combinational single iteration of the multiply/divide datapath.
// The accumulator is 2*WIDTH bits wide. Its meaning depends on the mode:
//   multiply: {partial product high half, remaining multiplier bits}
//             One shift-add step: add the operand (multiplicand) to the high
//             half when the current multiplier LSB is 1, then shift right.
//             The carry of the addition is shifted into the vacated bit.
//   divide:   {partial remainder, dividend bits / quotient bits}
//             One restoring step: shift left one bit, try to subtract the
//             operand (divisor), keep the difference and shift in a quotient
//             bit of 1 when there was no borrow.
// Ports:
//   isDiv    - 1 = divide step, 0 = multiply step
//   accIn    - current accumulator
//   operand  - multiplicand (multiply) or divisor (divide)
//   accOut   - accumulator after this iteration
// ---------------------------------------------------------------------------
module passo_mult_div
   import mult_div_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH
) (
   input  logic                 isDiv,
   input  logic [2*WIDTH-1:0]   accIn,
   input  logic [WIDTH-1:0]     operand,
   output logic [2*WIDTH-1:0]   accOut
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] remShift;
   logic [WIDTH:0] diff;

   // One iteration of either algorithm. Both candidate results are computed
   // every cycle and the mode picks one. The remainder shift is kept one bit
   // wider so the borrow of the trial subtraction lands in diff's MSB; the
   // partial remainder always stays below the divisor, so the surviving value
   // fits back into WIDTH bits.
   always_comb begin
      sum      = accIn[2*WIDTH-1:WIDTH] + (accIn[0] ? {1'b0, operand} : '0);
      remShift = {accIn[2*WIDTH-1:WIDTH], accIn[WIDTH-1]};
      diff     = remShift - {1'b0, operand};
      accOut   = {sum, accIn[WIDTH-1:1]};
      if (isDiv) begin
         if (!diff[WIDTH]) begin
            accOut = {diff[WIDTH-1:0], accIn[WIDTH-2:0], 1'b1};
         end else begin
            accOut = {remShift[WIDTH-1:0], accIn[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/unidade_mult_div.sv
// ---------------------------------------------------------------------------
// unidade_mult_div
// Iterative multiply/divide unit with architectural HI/LO registers.
// One bit per cycle: start is accepted in IDLE (edge E0), 32 iterations run in
// CALC (E1..E32), and the sign-corrected result is written into HI/LO in FIM
// (E33), with a one-cycle done pulse afterwards.
// Ports:
//   clock, reset       - clock; asynchronous active-high reset
//   start, op          - launch request and operation (MULT/MULTU/DIV/DIVU)
//   opA, opB           - RS / RT contents
//   wrHi, wrLo         - MTHI / MTLO writes of opA, honoured only when idle
//   selHi              - result mux select (1 = HI, 0 = LO)
//   busy               - operation in progress
//   done, divZero      - completion pulse and divide-by-zero flag with it
//   hi, lo, resultado  - HI/LO registers and the selected one
// ---------------------------------------------------------------------------
module unidade_mult_div
   import mult_div_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH,
   parameter int CNT_W = CNT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic             wrHi,
   input  logic             wrLo,
   input  logic             selHi,
   output logic             busy,
   output logic             done,
   output logic             divZero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] resultado
);

   stateT              stateQ, stateD;
   logic [CNT_W-1:0]   counterQ, counterD;
   logic [2*WIDTH-1:0] accQ, accD, accStep;
   logic [WIDTH-1:0]   operandQ, operandD;
   logic [WIDTH-1:0]   hiQ, hiD, loQ, loD;
   logic               isDivQ, isDivD;
   logic               negResQ, negResD;
   logic               negRemQ, negRemD;
   logic               dzQ, dzD;
   logic               busyQ, busyD;
   logic               doneQ, doneD;
   logic               divZeroQ, divZeroD;

   logic               opIsDiv, opIsSigned, byZero;
   logic [WIDTH-1:0]   magA, magB;
   logic [2*WIDTH-1:0] prodFinal;
   logic [WIDTH-1:0]   quoFinal, remFinal;

   passo_mult_div #(.WIDTH(WIDTH)) uPasso (
      .isDiv   (isDivQ),
      .accIn   (accQ),
      .operand (operandQ),
      .accOut  (accStep)
   );

   // Operand preparation at launch. A divide by zero deliberately keeps the
   // raw dividend and no sign flags: the restoring divider then naturally
   // produces an all-ones quotient and leaves the dividend as the remainder,
   // which is exactly the HI/LO result wanted for that case. The magnitude of
   // -2^WIDTH-1 wraps to itself, which is the correct unsigned magnitude.
   always_comb begin
      opIsDiv    = (op == OP_DIV) || (op == OP_DIVU);
      opIsSigned = (op == OP_MULT) || (op == OP_DIV);
      byZero     = opIsDiv && (opB == '0);
      magA       = (opIsSigned && !byZero && opA[WIDTH-1]) ? -opA : opA;
      magB       = (opIsSigned && opB[WIDTH-1]) ? -opB : opB;
      prodFinal  = negResQ ? -accQ : accQ;
      quoFinal   = negResQ ? -accQ[WIDTH-1:0] : accQ[WIDTH-1:0];
      remFinal   = negRemQ ? -accQ[2*WIDTH-1:WIDTH] : accQ[2*WIDTH-1:WIDTH];
   end

   // Next-state logic. In IDLE a start wins over MTHI/MTLO, so a write that
   // coincides with a launch is dropped. During CALC the accumulator takes
   // one datapath step per edge; FIM commits HI/LO and raises done. busy is
   // derived from the next state so it is a clean registered output that is
   // already low in the done cycle.
   always_comb begin
      stateD   = stateQ;
      counterD = counterQ;
      accD     = accQ;
      operandD = operandQ;
      hiD      = hiQ;
      loD      = loQ;
      isDivD   = isDivQ;
      negResD  = negResQ;
      negRemD  = negRemQ;
      dzD      = dzQ;
      doneD    = 1'b0;
      divZeroD = 1'b0;
      case (stateQ)
         IDLE: begin
            if (start) begin
               isDivD   = opIsDiv;
               accD     = {{WIDTH{1'b0}}, (opIsDiv ? magA : magB)};
               operandD = opIsDiv ? magB : magA;
               negResD  = opIsSigned && !byZero && (opA[WIDTH-1] ^ opB[WIDTH-1]);
               negRemD  = opIsSigned && !byZero && opA[WIDTH-1];
               dzD      = byZero;
               counterD = '0;
               stateD   = CALC;
            end else begin
               if (wrHi) begin
                  hiD = opA;
               end
               if (wrLo) begin
                  loD = opA;
               end
            end
         end
         CALC: begin
            accD     = accStep;
            counterD = counterQ + 1'b1;
            if (counterQ == CNT_W'(N_ITER - 1)) begin
               stateD = FIM;
            end
         end
         FIM: begin
            if (isDivQ) begin
               loD = quoFinal;
               hiD = remFinal;
            end else begin
               hiD = prodFinal[2*WIDTH-1:WIDTH];
               loD = prodFinal[WIDTH-1:0];
            end
            doneD    = 1'b1;
            divZeroD = dzQ;
            stateD   = IDLE;
         end
         default: begin
            stateD = IDLE;
         end
      endcase
      busyD = (stateD != IDLE);
   end

   // State register. Reset aborts any operation in flight and clears HI/LO
   // immediately, so no done pulse or partial result can escape.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stateQ   <= IDLE;
         counterQ <= '0;
         accQ     <= '0;
         operandQ <= '0;
         hiQ      <= '0;
         loQ      <= '0;
         isDivQ   <= 1'b0;
         negResQ  <= 1'b0;
         negRemQ  <= 1'b0;
         dzQ      <= 1'b0;
         busyQ    <= 1'b0;
         doneQ    <= 1'b0;
         divZeroQ <= 1'b0;
      end else begin
         stateQ   <= stateD;
         counterQ <= counterD;
         accQ     <= accD;
         operandQ <= operandD;
         hiQ      <= hiD;
         loQ      <= loD;
         isDivQ   <= isDivD;
         negResQ  <= negResD;
         negRemQ  <= negRemD;
         dzQ      <= dzD;
         busyQ    <= busyD;
         doneQ    <= doneD;
         divZeroQ <= divZeroD;
      end
   end

   // Outputs straight from registers; the result mux has no bypass of an
   // operation still in flight.
   always_comb begin
      busy      = busyQ;
      done      = doneQ;
      divZero   = divZeroQ;
      hi        = hiQ;
      lo        = loQ;
      resultado = selHi ? hiQ : loQ;
   end

endmodule

// File: tb/tb_unidade_mult_div.sv
// ---------------------------------------------------------------------------
// tb_unidade_mult_div
// Directed-vector bench for the multiply/divide unit. Expected HI/LO values
// are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_unidade_mult_div;

   logic        clock;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] opA;
   logic [31:0] opB;
   logic        wrHi;
   logic        wrLo;
   logic        selHi;
   logic        busy;
   logic        done;
   logic        divZero;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] resultado;

   int vectorCount = 0;
   int missCount   = 0;
   int cycles;
   int busyCycles;
   int doneSeen;

   unidade_mult_div dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .opA       (opA),
      .opB       (opB),
      .wrHi      (wrHi),
      .wrLo      (wrLo),
      .selHi     (selHi),
      .busy      (busy),
      .done      (done),
      .divZero   (divZero),
      .hi        (hi),
      .lo        (lo),
      .resultado (resultado)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Single comparison point: counts every vector and reports miscompares.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Launch an operation from a point just after a rising edge. After the
   // accepting edge the operand/op inputs are scrambled so that any use of
   // them past the launch would corrupt the result.
   task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op    = o;
      opA   = a;
      opB   = b;
      @(posedge clock);
      #1;
      start = 1'b0;
      op    = 2'b11;
      opA   = 32'hDEADBEEF;
      opB   = 32'h0;
   endtask

   // Wait (bounded) for done, counting cycles and cycles where busy was high.
   task automatic waitDone(output int nCycles, output int nBusy);
      nCycles = 0;
      nBusy   = 0;
      while (!done && nCycles < 60) begin
         if (busy) nBusy++;
         @(posedge clock);
         #1;
         nCycles++;
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      opA   = '0;
      opB   = '0;
      wrHi  = 1'b0;
      wrLo  = 1'b0;
      selHi = 1'b0;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      checkOutput("rstHi", hi, 32'h0);
      checkOutput("rstLo", lo, 32'h0);
      checkOutput("rstBusy", 32'(busy), 32'h0);
      checkOutput("rstDone", 32'(done), 32'h0);
      checkOutput("rstDivZero", 32'(divZero), 32'h0);
      checkOutput("rstResultado", resultado, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // MULTU 0xFFFFFFFF * 0xFFFFFFFF
      applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      waitDone(cycles, busyCycles);
      checkOutput("multuLatency", 32'(cycles), 32'd33);
      checkOutput("multuBusyCycles", 32'(busyCycles), 32'd33);
      checkOutput("multuHi", hi, 32'hFFFFFFFE);
      checkOutput("multuLo", lo, 32'h00000001);
      checkOutput("multuBusyInDone", 32'(busy), 32'h0);
      checkOutput("multuDivZero", 32'(divZero), 32'h0);
      @(posedge clock);
      #1;
      checkOutput("multuDonePulse", 32'(done), 32'h0);

      // MULT -3 * 5
      applyStimulus(2'b00, 32'hFFFFFFFD, 32'h00000005);
      waitDone(cycles, busyCycles);
      checkOutput("multHi", hi, 32'hFFFFFFFF);
      checkOutput("multLo", lo, 32'hFFFFFFF1);
      selHi = 1'b1;
      #1;
      checkOutput("multResHi", resultado, 32'hFFFFFFFF);
      selHi = 1'b0;
      #1;
      checkOutput("multResLo", resultado, 32'hFFFFFFF1);
      @(posedge clock);
      #1;

      // MULT -1 * -2^31 = +2^31
      applyStimulus(2'b00, 32'hFFFFFFFF, 32'h80000000);
      waitDone(cycles, busyCycles);
      checkOutput("multMinHi", hi, 32'h00000000);
      checkOutput("multMinLo", lo, 32'h80000000);

      // DIV -7 / 2
      applyStimulus(2'b10, 32'hFFFFFFF9, 32'h00000002);
      waitDone(cycles, busyCycles);
      checkOutput("divLo", lo, 32'hFFFFFFFD);
      checkOutput("divHi", hi, 32'hFFFFFFFF);
      checkOutput("divDivZero", 32'(divZero), 32'h0);
      checkOutput("divDone", 32'(done), 32'h1);

      // DIV -2^31 / -1, started in the done cycle of the previous divide
      applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF);
      waitDone(cycles, busyCycles);
      checkOutput("divOvfLatency", 32'(cycles), 32'd33);
      checkOutput("divOvfLo", lo, 32'h80000000);
      checkOutput("divOvfHi", hi, 32'h00000000);

      // DIVU 0x1234 / 0
      applyStimulus(2'b11, 32'h00001234, 32'h00000000);
      waitDone(cycles, busyCycles);
      checkOutput("divuZeroLatency", 32'(cycles), 32'd33);
      checkOutput("divuZeroLo", lo, 32'hFFFFFFFF);
      checkOutput("divuZeroHi", hi, 32'h00001234);
      checkOutput("divuZeroFlag", 32'(divZero), 32'h1);
      checkOutput("divuZeroDone", 32'(done), 32'h1);
      @(posedge clock);
      #1;
      checkOutput("divuZeroFlagPulse", 32'(divZero), 32'h0);
      checkOutput("divuZeroDonePulse", 32'(done), 32'h0);

      // DIV -7 / 0: HI keeps the raw dividend
      applyStimulus(2'b10, 32'hFFFFFFF9, 32'h00000000);
      waitDone(cycles, busyCycles);
      checkOutput("divZeroNegLo", lo, 32'hFFFFFFFF);
      checkOutput("divZeroNegHi", hi, 32'hFFFFFFF9);
      checkOutput("divZeroNegFlag", 32'(divZero), 32'h1);
      @(posedge clock);
      #1;

      // MTHI alone, then MTHI + MTLO together
      wrHi = 1'b1;
      opA  = 32'hAAAA5555;
      @(posedge clock);
      #1;
      wrHi = 1'b0;
      checkOutput("mthiHi", hi, 32'hAAAA5555);
      checkOutput("mthiLoKept", lo, 32'hFFFFFFFF);
      wrHi = 1'b1;
      wrLo = 1'b1;
      opA  = 32'h12345678;
      @(posedge clock);
      #1;
      wrHi = 1'b0;
      wrLo = 1'b0;
      checkOutput("mtBothHi", hi, 32'h12345678);
      checkOutput("mtBothLo", lo, 32'h12345678);

      // MTHI/MTLO coincident with start are dropped
      wrHi = 1'b1;
      wrLo = 1'b1;
      applyStimulus(2'b01, 32'h00000006, 32'h00000007);
      checkOutput("wrWithStartHi", hi, 32'h12345678);
      checkOutput("wrWithStartLo", lo, 32'h12345678);

      // Second start and writes while busy are ignored
      start = 1'b1;
      op    = 2'b11;
      opA   = 32'h0000FFFF;
      opB   = 32'h00000003;
      repeat (5) @(posedge clock);
      #1;
      start = 1'b0;
      wrHi  = 1'b0;
      wrLo  = 1'b0;
      checkOutput("busyWrLo", lo, 32'h12345678);
      checkOutput("busyWrHi", hi, 32'h12345678);
      waitDone(cycles, busyCycles);
      checkOutput("busyStartLatency", 32'(cycles), 32'd28);
      checkOutput("busyStartHi", hi, 32'h00000000);
      checkOutput("busyStartLo", lo, 32'h0000002A);
      @(posedge clock);
      #1;
      checkOutput("busyStartNoRelaunch", 32'(busy), 32'h0);

      // Reset in the middle of CALC
      applyStimulus(2'b01, 32'h00000003, 32'h00000004);
      repeat (10) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("abortHi", hi, 32'h0);
      checkOutput("abortLo", lo, 32'h0);
      checkOutput("abortBusy", 32'(busy), 32'h0);
      @(negedge clock);
      reset = 1'b0;
      doneSeen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         if (done) doneSeen++;
      end
      checkOutput("abortNoDone", 32'(doneSeen), 32'h0);
      checkOutput("abortLoAfter", lo, 32'h0);

      // Start accepted in the done cycle
      applyStimulus(2'b11, 32'd100, 32'd7);
      waitDone(cycles, busyCycles);
      checkOutput("divuLo", lo, 32'd14);
      checkOutput("divuHi", hi, 32'd2);
      applyStimulus(2'b00, 32'hFFFFFFFE, 32'h00000003);
      waitDone(cycles, busyCycles);
      checkOutput("backToBackLatency", 32'(cycles), 32'd33);
      checkOutput("backToBackHi", hi, 32'hFFFFFFFF);
      checkOutput("backToBackLo", lo, 32'hFFFFFFFA);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
